// File: rtl/asyn_fifo_arb_pkg.sv
// Shared types and helpers for the asyn_fifo write-side arbiters.
// Holds the arbiter state encoding and the circular first-set search.
package asyn_fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_t;

  localparam int RR_MAX = 8;

  // Winner is the first set bit at or after ptr, wrapping at n.
  function automatic logic [2:0] rr_pick(
    input logic [RR_MAX-1:0] req,
    input logic [2:0]        ptr,
    input int                n
  );
    logic [2:0] win;
    logic       found;
    int         idx;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < RR_MAX; k++) begin
      idx = int'(ptr) + k;
      if (idx >= n) idx = idx - n;
      if (k < n && !found && req[idx]) begin
        win   = 3'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/asyn_fifo_wr_arbiter_if.sv
// Producer beat handshakes plus the asyn_fifo write port.
// master = producers/FIFO side, slave = arbiter side.
interface asyn_fifo_wr_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 11
);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_last;
  logic [NUM_REQ*DATA_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         fifo_full;
  logic                         fifo_write;
  logic [DATA_BITS-1:0]         fifo_data;

  modport master (
    output req_valid,
    output req_last,
    output req_data,
    output fifo_full,
    input  req_ready,
    input  fifo_write,
    input  fifo_data
  );

  modport slave (
    input  req_valid,
    input  req_last,
    input  req_data,
    input  fifo_full,
    output req_ready,
    output fifo_write,
    output fifo_data
  );

endinterface

// File: rtl/rr_priority_pick.sv
// Circular first-set search over NUM_REQ request bits.
// Pure combinational; shared by the asyn_fifo arbiters.
module rr_priority_pick
  import asyn_fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_BITS = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_BITS-1:0] ptr,
  output logic [ID_BITS-1:0] win
);

  assign win = ID_BITS'(rr_pick(RR_MAX'(req), 3'(ptr), NUM_REQ));

endmodule

// File: rtl/asyn_fifo_wr_arbiter.sv
// Round-robin arbiter sharing the asyn_fifo write port.
// One producer holds a grant for at most MAX_BURST beats.
module asyn_fifo_wr_arbiter
  import asyn_fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int DATA_BITS = 11,
  parameter  int MAX_BURST = 8,
  parameter  int CNT_BITS  = 16,
  localparam int ID_BITS   = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  asyn_fifo_wr_arbiter_if.slave bus,
  output logic                grant_valid,
  output logic [ID_BITS-1:0]  grant_id,
  output logic [CNT_BITS-1:0] beat_count
);

  arb_state_t         state;
  arb_state_t         state_nx;
  logic [ID_BITS-1:0] rr_ptr;
  logic [ID_BITS-1:0] gid;
  logic [ID_BITS-1:0] win;
  logic [ID_BITS-1:0] ptr_nx;
  logic [7:0]         burst_cnt;
  logic               cur_valid;
  logic               cur_last;
  logic               cap_hit;
  logic               xfer;
  logic               rel;
  logic               start;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req (bus.req_valid),
    .ptr (rr_ptr),
    .win (win)
  );

  assign grant_valid = (state == ARB_GRANT);
  assign grant_id    = gid;
  assign cur_valid   = bus.req_valid[gid];
  assign cur_last    = bus.req_last[gid];
  assign cap_hit     = (burst_cnt + 8'd1) == 8'(MAX_BURST);
  assign xfer        = grant_valid & cur_valid
                     & ~bus.fifo_full;
  // A full stall keeps valid high, so only a real drop releases.
  assign rel         = grant_valid
                     & ((xfer & (cur_last | cap_hit))
                        | ~cur_valid);
  assign start       = ~grant_valid & enable
                     & (|bus.req_valid);
  assign ptr_nx      = (gid == ID_BITS'(NUM_REQ - 1))
                     ? '0 : gid + 1'b1;

  assign bus.fifo_write = xfer;
  assign bus.fifo_data  = grant_valid
    ? bus.req_data[gid*DATA_BITS +: DATA_BITS]
    : '0;

  always_comb begin
    bus.req_ready      = '0;
    bus.req_ready[gid] = xfer;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ARB_IDLE:  if (start) state_nx = ARB_GRANT;
      ARB_GRANT: if (rel)   state_nx = ARB_IDLE;
      default:   state_nx = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ARB_IDLE;
      rr_ptr     <= '0;
      gid        <= '0;
      burst_cnt  <= '0;
      beat_count <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        gid       <= win;
        burst_cnt <= '0;
      end
      if (xfer) begin
        burst_cnt  <= burst_cnt + 8'd1;
        beat_count <= beat_count + 1'b1;
      end
      if (rel) rr_ptr <= ptr_nx;
    end
  end

endmodule

// File: tb/tb_asyn_fifo_wr_arbiter.sv
// Directed bench for asyn_fifo_wr_arbiter: vector table
// plus hand-written multi-cycle sequences.
module tb_asyn_fifo_wr_arbiter;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic [15:0] beat_count;

  int checks;
  int errors;

  asyn_fifo_wr_arbiter_if #(
    .NUM_REQ   (4),
    .DATA_BITS (11)
  ) bus ();

  asyn_fifo_wr_arbiter #(
    .NUM_REQ   (4),
    .DATA_BITS (11),
    .MAX_BURST (8),
    .CNT_BITS  (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .bus         (bus.slave),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .beat_count  (beat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          en;
    logic [3:0]  v;
    logic [3:0]  l;
    bit          full;
    logic [7:0]  base;
    bit          gv;
    logic [1:0]  gid;
    bit          fw;
    logic [3:0]  rdy;
    logic [10:0] data;
    logic [15:0] bc;
  } vec_t;

  vec_t tv[$];

  function automatic void chk(string name,
                              logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, act, exp);
    end
  endfunction

  task automatic add(bit rst, bit en, logic [3:0] v,
                     logic [3:0] l, logic [7:0] base,
                     bit gv, logic [1:0] gid, bit fw,
                     logic [3:0] rdy, logic [10:0] data,
                     logic [15:0] bc);
    vec_t r;
    r.rst = rst;   r.en = en;   r.v = v;
    r.l = l;       r.full = 1'b0; r.base = base;
    r.gv = gv;     r.gid = gid; r.fw = fw;
    r.rdy = rdy;   r.data = data; r.bc = bc;
    tv.push_back(r);
  endtask

  task automatic set_data(int i, logic [10:0] d);
    bus.req_data[i*11 +: 11] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset         = 1'b0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    logic [10:0] got[$];
    int lens[$];
    int idles[$];
    int k, cur, idle, stall, c;
    bit resumed;

    checks        = 0;
    errors        = 0;
    reset         = 1'b0;
    enable        = 1'b0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;

    // single requester, 3-beat packet
    add(1,1,4'b0001,4'b0000,8'h10, 0,0,0,4'b0000,11'h000,0);
    add(0,1,4'b0001,4'b0000,8'h10, 1,0,1,4'b0001,11'h010,0);
    add(0,1,4'b0001,4'b0000,8'h11, 1,0,1,4'b0001,11'h011,1);
    add(0,1,4'b0001,4'b0001,8'h12, 1,0,1,4'b0001,11'h012,2);
    add(0,1,4'b0000,4'b0000,8'h00, 0,0,0,4'b0000,11'h000,3);
    // round robin 0,1,2 then 0 again
    add(1,1,4'b0111,4'b0000,8'h20, 0,0,0,4'b0000,11'h000,0);
    add(0,1,4'b0111,4'b0000,8'h21, 1,0,1,4'b0001,11'h021,0);
    add(0,1,4'b0111,4'b0001,8'h22, 1,0,1,4'b0001,11'h022,1);
    add(0,1,4'b0111,4'b0000,8'h23, 0,0,0,4'b0000,11'h000,2);
    add(0,1,4'b0111,4'b0000,8'h24, 1,1,1,4'b0010,11'h124,2);
    add(0,1,4'b0111,4'b0010,8'h25, 1,1,1,4'b0010,11'h125,3);
    add(0,1,4'b0111,4'b0000,8'h26, 0,0,0,4'b0000,11'h000,4);
    add(0,1,4'b0111,4'b0000,8'h27, 1,2,1,4'b0100,11'h227,4);
    add(0,1,4'b0111,4'b0100,8'h28, 1,2,1,4'b0100,11'h228,5);
    add(0,1,4'b0011,4'b0000,8'h29, 0,0,0,4'b0000,11'h000,6);
    add(0,1,4'b0011,4'b0000,8'h2a, 1,0,1,4'b0001,11'h02a,6);
    add(0,1,4'b0011,4'b0001,8'h2b, 1,0,1,4'b0001,11'h02b,7);
    add(0,1,4'b0000,4'b0000,8'h2c, 0,0,0,4'b0000,11'h000,8);

    foreach (tv[n]) begin
      if (tv[n].rst) do_reset();
      @(negedge clk);
      enable        = tv[n].en;
      bus.req_valid = tv[n].v;
      bus.req_last  = tv[n].l;
      bus.fifo_full = tv[n].full;
      for (int i = 0; i < 4; i++)
        set_data(i, {3'(i), tv[n].base});
      #1;
      chk($sformatf("r%0d_gv", n), 32'(grant_valid),
          32'(tv[n].gv));
      if (tv[n].gv)
        chk($sformatf("r%0d_gid", n), 32'(grant_id),
            32'(tv[n].gid));
      chk($sformatf("r%0d_fw", n), 32'(bus.fifo_write),
          32'(tv[n].fw));
      chk($sformatf("r%0d_rdy", n), 32'(bus.req_ready),
          32'(tv[n].rdy));
      chk($sformatf("r%0d_data", n), 32'(bus.fifo_data),
          32'(tv[n].data));
      chk($sformatf("r%0d_bc", n), 32'(beat_count),
          32'(tv[n].bc));
    end

    // burst cap: req 3 streams 20 beats, no last
    do_reset();
    enable = 1'b1;
    k = 0; cur = 0; idle = 0; c = 0;
    while (c < 100) begin
      @(negedge clk);
      bus.req_valid = (k < 20) ? 4'b1000 : 4'b0000;
      bus.req_last  = '0;
      set_data(3, 11'(k));
      #1;
      if (bus.fifo_write) begin
        chk("cap_data", 32'(bus.fifo_data), 32'(k));
        cur++;
      end
      if (grant_valid && idle > 0) begin
        idles.push_back(idle);
        idle = 0;
      end
      if (!grant_valid && k < 20) idle++;
      if (!grant_valid && cur > 0) begin
        lens.push_back(cur);
        cur = 0;
      end
      if (bus.req_ready[3]) k++;
      c++;
      if (k >= 20 && !grant_valid && cur == 0) break;
    end
    chk("cap_timeout", 32'(c < 100), 32'd1);
    chk("cap_ngrants", 32'(lens.size()), 32'd3);
    if (lens.size() == 3) begin
      chk("cap_len0", 32'(lens[0]), 32'd8);
      chk("cap_len1", 32'(lens[1]), 32'd8);
      chk("cap_len2", 32'(lens[2]), 32'd4);
    end
    chk("cap_nbubbles", 32'(idles.size()), 32'd3);
    foreach (idles[i])
      chk("cap_bubble", 32'(idles[i]), 32'd1);
    chk("cap_bc", 32'(beat_count), 32'd20);
    // last release came from 3, so pointer wrapped to 0
    @(negedge clk);
    bus.req_valid = 4'b1001;
    #1 chk("wrap_idle", 32'(grant_valid), 32'd0);
    @(negedge clk);
    #1 chk("wrap_gv", 32'(grant_valid), 32'd1);
    chk("wrap_gid", 32'(grant_id), 32'd0);

    // backpressure: full for 5 cycles after 2 beats
    do_reset();
    enable = 1'b1;
    k = 0; stall = 0; c = 0; resumed = 1'b0;
    while (c < 60) begin
      @(negedge clk);
      bus.req_valid = (k < 6) ? 4'b0010 : 4'b0000;
      bus.req_last  = (k == 5) ? 4'b0010 : 4'b0000;
      set_data(1, 11'h100 + 11'(k));
      bus.fifo_full = (k == 2 && stall < 5);
      #1;
      if (bus.fifo_full) begin
        stall++;
        chk("bp_fw", 32'(bus.fifo_write), 32'd0);
        chk("bp_rdy", 32'(bus.req_ready), 32'd0);
        chk("bp_gv", 32'(grant_valid), 32'd1);
        chk("bp_gid", 32'(grant_id), 32'd1);
      end else if (stall == 5 && !resumed) begin
        chk("bp_resume", 32'(bus.fifo_write), 32'd1);
        resumed = 1'b1;
      end
      if (bus.fifo_write) got.push_back(bus.fifo_data);
      if (bus.req_ready[1]) k++;
      c++;
      if (k == 6 && !grant_valid) break;
    end
    bus.fifo_full = 1'b0;
    chk("bp_timeout", 32'(c < 60), 32'd1);
    chk("bp_nbeats", 32'(got.size()), 32'd6);
    foreach (got[i])
      chk("bp_order", 32'(got[i]), 32'h100 + 32'(i));
    chk("bp_bc", 32'(beat_count), 32'd6);

    // enable low during grant: packet finishes, then idle
    do_reset();
    enable = 1'b1;
    @(negedge clk);
    bus.req_valid = 4'b0100;
    bus.req_last  = 4'b0000;
    #1 chk("en_idle", 32'(grant_valid), 32'd0);
    @(negedge clk);
    enable = 1'b0;
    #1 chk("en_b0", 32'(bus.fifo_write), 32'd1);
    chk("en_gid", 32'(grant_id), 32'd2);
    @(negedge clk);
    #1 chk("en_b1", 32'(bus.fifo_write), 32'd1);
    @(negedge clk);
    bus.req_last = 4'b0100;
    #1 chk("en_b2", 32'(bus.fifo_write), 32'd1);
    @(negedge clk);
    bus.req_last = 4'b0000;
    #1 chk("en_rel", 32'(grant_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk("en_hold", 32'(grant_valid), 32'd0);
    end
    @(negedge clk);
    enable = 1'b1;
    #1 chk("en_back_idle", 32'(grant_valid), 32'd0);
    @(negedge clk);
    #1 chk("en_back_gv", 32'(grant_valid), 32'd1);
    chk("en_bc", 32'(beat_count), 32'd3);

    // drop mid-packet: release, pointer moves to id+1
    do_reset();
    enable = 1'b1;
    @(negedge clk);
    bus.req_valid = 4'b0010;
    bus.req_last  = 4'b0000;
    #1 chk("dr_idle", 32'(grant_valid), 32'd0);
    @(negedge clk);
    #1 chk("dr_fw", 32'(bus.fifo_write), 32'd1);
    chk("dr_gid", 32'(grant_id), 32'd1);
    @(negedge clk);
    bus.req_valid = 4'b0101;
    #1 chk("dr_gv", 32'(grant_valid), 32'd1);
    chk("dr_nofw", 32'(bus.fifo_write), 32'd0);
    chk("dr_rdy", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    #1 chk("dr_bubble", 32'(grant_valid), 32'd0);
    @(negedge clk);
    #1 chk("dr_next_gv", 32'(grant_valid), 32'd1);
    chk("dr_next_gid", 32'(grant_id), 32'd2);

    // async reset mid-burst; arbitration restarts at 0
    do_reset();
    enable = 1'b1;
    @(negedge clk);
    bus.req_valid = 4'b0100;
    bus.req_last  = 4'b0100;
    #1 chk("ar_idle", 32'(grant_valid), 32'd0);
    @(negedge clk);
    #1 chk("ar_one", 32'(bus.fifo_write), 32'd1);
    @(negedge clk);
    bus.req_valid = 4'b1000;
    bus.req_last  = 4'b0000;
    @(negedge clk);
    #1 chk("ar_gid3", 32'(grant_id), 32'd3);
    @(negedge clk);
    #1 chk("ar_fw3", 32'(bus.fifo_write), 32'd1);
    #2 reset = 1'b0;
    #1 chk("ar_fw", 32'(bus.fifo_write), 32'd0);
    chk("ar_rdy", 32'(bus.req_ready), 32'd0);
    chk("ar_gv", 32'(grant_valid), 32'd0);
    chk("ar_bc", 32'(beat_count), 32'd0);
    @(negedge clk);
    reset         = 1'b1;
    bus.req_valid = 4'b1001;
    #1 chk("ar_post_idle", 32'(grant_valid), 32'd0);
    @(negedge clk);
    #1 chk("ar_post_gv", 32'(grant_valid), 32'd1);
    chk("ar_post_gid", 32'(grant_id), 32'd0);

    bus.req_valid = '0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/asyn_fifo_wr_arbiter.md
Name: asyn_fifo_wr_arbiter

Overview:
Round-robin write-port arbiter that shares the write side of asyn_fifo between NUM_REQ producers. Each producer offers beats through a valid/ready/last handshake. The arbiter grants one producer at a time for a bounded burst, steers its data onto the FIFO write port, and applies FIFO full as backpressure. It sits in the write clock domain directly in front of asyn_fifo.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
DATA_BITS, 11, FIFO data width; must match asyn_fifo DATA_BITS.
MAX_BURST, 8, maximum beats per grant (1..255).
ID_BITS, $clog2(NUM_REQ), localparam, grant index width.
CNT_BITS, 16, width of the beat_count statistic.

Ports:
clk  in  1  write-domain clock; all state on rising edge.
reset  in  1  asynchronous, active-low reset.
enable  in  1  1 = new grants allowed; 0 = finish current grant, then hold IDLE.
req_valid  in  NUM_REQ  per-requester beat valid.
req_last  in  NUM_REQ  per-requester last beat of packet; qualified by valid.
req_data  in  NUM_REQ*DATA_BITS  packed beat data; requester i occupies bits [i*DATA_BITS +: DATA_BITS].
req_ready  out  NUM_REQ  per-requester beat accepted this cycle.
fifo_full  in  1  asyn_fifo full flag.
fifo_write  out  1  asyn_fifo write strobe.
fifo_data  out  DATA_BITS  asyn_fifo input_data.
grant_valid  out  1  a grant is held (state GRANT).
grant_id  out  ID_BITS  index of granted requester; valid when grant_valid = 1.
beat_count  out  CNT_BITS  total beats written since reset; wraps modulo 2^CNT_BITS.

Behaviour:
- Reset (reset = 0, asynchronous): state IDLE, rr_ptr 0, burst_cnt 0, grant_id 0, beat_count 0. grant_valid, fifo_write and every req_ready are 0 while reset is low. Deassertion is synchronised by the caller.
- FSM states: IDLE and GRANT.
- IDLE -> GRANT: enable = 1 and any req_valid set. Winner is the first set bit searching circularly from rr_ptr. Register grant_id = winner and clear burst_cnt. Arbitration latency is 1 cycle; no beat transfers in IDLE.
- GRANT, transfer condition: xfer = req_valid[grant_id] & ~fifo_full. This is combinational from registered state.
- fifo_write = xfer.
- req_ready[grant_id] = xfer. All other req_ready bits are 0.
- fifo_data = req_data slice of grant_id whenever grant_valid = 1, and 0 in IDLE.
- On each xfer: burst_cnt += 1 and beat_count += 1.
- GRANT -> IDLE (release) when any of the following holds:
  - (a) xfer with req_last[grant_id] = 1;
  - (b) xfer and burst_cnt + 1 == MAX_BURST;
  - (c) req_valid[grant_id] = 0 for one cycle (a drop releases; a stall due to full does not).
- On release: rr_ptr = (grant_id + 1) mod NUM_REQ, and the next cycle is IDLE. This gives one bubble cycle between grants by design.
- fifo_full = 1 in GRANT: no transfer, no release, grant is held indefinitely.
- enable = 0 during GRANT: no effect until release; enable is only sampled in IDLE.
- A requester dropping valid mid-packet loses the grant. Its packet resumes on a later grant (no interleave guarantee across requesters).
- Simultaneous release and new requests: the new grant is decided in the following IDLE cycle using the updated rr_ptr.
- Reset asserted mid-burst: outputs clear immediately. Beats already written remain in the FIFO.

Decomposition:
- Package asyn_fifo_arb_pkg holds:
  - typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;
  - a function rr_pick(req, ptr) returning the winner index.
- Sub-module rr_priority_pick (pure combinational, NUM_REQ parameterised) implements the circular first-set search and is reused by later arbiters.

Test Plan:
- Single requester: req 0 sends 3 beats 0x10,0x11,0x12 (last on the third), full = 0 -> grant_valid rises 1 cycle after valid; 3 consecutive fifo_write; release; beat_count = 3.
- Round-robin: reqs 0,1,2 each hold valid with a 2-beat packet -> grant order 0,1,2 with one IDLE bubble between grants; a fourth packet from 0 is granted only after 2.
- Burst cap: MAX_BURST = 8, req 3 streams 20 beats without last -> grants of 8,8,4 beats; rr_ptr advances to 0 after each release; other requesters are interleaved if they are valid.
- Backpressure: fifo_full held high for 5 cycles mid-packet -> fifo_write = 0, req_ready = 0, grant_id unchanged; transfer resumes the cycle after full drops; no beat is lost or duplicated (compare against FIFO read-side data order).
- Enable/drop: enable goes low during a grant -> the grant finishes its packet, then stays in IDLE. A requester dropping valid mid-packet -> release after 1 cycle and rr_ptr = id + 1.
- Async reset mid-burst: assert reset between edges -> fifo_write, req_ready and grant_valid go 0 immediately, beat_count = 0. After release, arbitration restarts from requester 0.
